// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Front-panel controller for the digital clock. Sequences the set/alarm mode
// state machine from the debounced MODE button. Issues single-cycle increment
// pulses from the debounced INC button, with press-and-hold auto-repeat. Also
// generates the periodic sample strobe that paces button debouncing.
//
// Ports:
//   cclk        in   system clock, all logic on the rising edge
//   clr         in   asynchronous active-low reset
//   btn_mode    in   debounced MODE button level (cclk domain)
//   btn_inc     in   debounced INC button level (cclk domain)
//   sample_en   out  one-cycle strobe every SAMPLE_DIV cycles
//   mode        out  current state: RUN=0 SET_HR=1 SET_MIN=2 AL_HR=3 AL_MIN=4
//   alarm_d     out  1 while an alarm-setting state is active
//   run_en      out  1 while the time-of-day counter may advance
//   inc_hr      out  one-cycle pulse: increment clock hours
//   inc_min     out  one-cycle pulse: increment clock minutes
//   al_inc_hr   out  one-cycle pulse: increment alarm hours
//   al_inc_min  out  one-cycle pulse: increment alarm minutes
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int unsigned SAMPLE_DIV   = 500000,
    parameter int unsigned HOLD_TICKS   = 100,
    parameter int unsigned REPEAT_TICKS = 20,
    parameter int unsigned IDLE_TICKS   = 1000
) (
    input  logic       cclk,
    input  logic       clr,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sample_en,
    output logic [2:0] mode,
    output logic       alarm_d,
    output logic       run_en,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       al_inc_hr,
    output logic       al_inc_min
);

    localparam int unsigned PS_W   = $clog2(SAMPLE_DIV) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS) + 1;
    localparam int unsigned REP_W  = $clog2(REPEAT_TICKS) + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_TICKS) + 1;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        AL_HR   = 3'd3,
        AL_MIN  = 3'd4
    } state_t;

    // Prescaler
    logic [PS_W-1:0]   presc;

    // Button edge detect
    logic              mode_q;
    logic              inc_q;
    logic              rise_mode;
    logic              rise_inc;

    // State machine and counters
    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_nxt;
    logic              rep_phase;
    logic              rep_phase_nxt;
    logic              active;
    logic              active_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;
    logic              in_set;
    logic              fire;
    logic [3:0]        pulse_nxt;
    logic              alarm_nxt;
    logic              run_nxt;

    assign rise_mode = btn_mode & ~mode_q;
    assign rise_inc  = btn_inc  & ~inc_q;
    assign mode      = state;

    // -------------------------------------------------------------------------
    // Free-running sample prescaler
    // -------------------------------------------------------------------------
    always_ff @(posedge cclk or negedge clr) begin
        if (!clr) begin
            presc     <= '0;
            sample_en <= 1'b0;
        end else begin
            if (presc == PS_W'(SAMPLE_DIV - 1)) begin
                presc     <= '0;
                sample_en <= 1'b1;
            end else begin
                presc     <= presc + 1'b1;
                sample_en <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge cclk or negedge clr) begin
        if (!clr) begin
            mode_q     <= 1'b0;
            inc_q      <= 1'b0;
            state      <= RUN;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            rep_phase  <= 1'b0;
            active     <= 1'b0;
            idle_cnt   <= '0;
            inc_hr     <= 1'b0;
            inc_min    <= 1'b0;
            al_inc_hr  <= 1'b0;
            al_inc_min <= 1'b0;
            alarm_d    <= 1'b0;
            run_en     <= 1'b1;
        end else begin
            mode_q     <= btn_mode;
            inc_q      <= btn_inc;
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            rep_cnt    <= rep_nxt;
            rep_phase  <= rep_phase_nxt;
            active     <= active_nxt;
            idle_cnt   <= idle_nxt;
            inc_hr     <= pulse_nxt[0];
            inc_min    <= pulse_nxt[1];
            al_inc_hr  <= pulse_nxt[2];
            al_inc_min <= pulse_nxt[3];
            alarm_d    <= alarm_nxt;
            run_en     <= run_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, hold/repeat and idle logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        rep_nxt       = rep_cnt;
        rep_phase_nxt = rep_phase;
        active_nxt    = active;
        idle_nxt      = idle_cnt;
        fire          = 1'b0;
        in_set        = state inside {SET_HR, SET_MIN, AL_HR, AL_MIN};

        if (rise_mode) begin
            // A mode edge wins over everything; a coincident INC edge is
            // dropped and a held INC stays inert until pressed again.
            case (state)
                RUN:     state_nxt = SET_HR;
                SET_HR:  state_nxt = SET_MIN;
                SET_MIN: state_nxt = AL_HR;
                AL_HR:   state_nxt = AL_MIN;
                default: state_nxt = RUN;
            endcase
            hold_nxt      = '0;
            rep_nxt       = '0;
            rep_phase_nxt = 1'b0;
            active_nxt    = 1'b0;
            idle_nxt      = '0;
        end else if (!in_set) begin
            // RUN ignores INC; unused codes fall back to RUN.
            state_nxt     = RUN;
            hold_nxt      = '0;
            rep_nxt       = '0;
            rep_phase_nxt = 1'b0;
            active_nxt    = 1'b0;
            idle_nxt      = '0;
        end else begin
            if (rise_inc) begin
                fire          = 1'b1;
                active_nxt    = 1'b1;
                rep_phase_nxt = 1'b0;
                hold_nxt      = '0;
                rep_nxt       = '0;
            end else if (!btn_inc) begin
                active_nxt    = 1'b0;
                rep_phase_nxt = 1'b0;
                hold_nxt      = '0;
                rep_nxt       = '0;
            end else if (active && sample_en) begin
                if (!rep_phase) begin
                    if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                        fire          = 1'b1;
                        rep_phase_nxt = 1'b1;
                        hold_nxt      = '0;
                        rep_nxt       = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end else begin
                    if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
                        fire    = 1'b1;
                        rep_nxt = '0;
                    end else begin
                        rep_nxt = rep_cnt + 1'b1;
                    end
                end
            end

            // Any button activity or emitted pulse restarts the idle window,
            // so a timeout can never coincide with a pulse.
            if (rise_inc || fire) begin
                idle_nxt = '0;
            end else if (sample_en) begin
                if (idle_cnt == IDLE_W'(IDLE_TICKS - 1)) begin
                    state_nxt     = RUN;
                    idle_nxt      = '0;
                    active_nxt    = 1'b0;
                    rep_phase_nxt = 1'b0;
                    hold_nxt      = '0;
                    rep_nxt       = '0;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (registered alongside the state)
    // -------------------------------------------------------------------------
    always_comb begin
        pulse_nxt = '0;
        if (fire) begin
            case (state)
                SET_HR:  pulse_nxt[0] = 1'b1;
                SET_MIN: pulse_nxt[1] = 1'b1;
                AL_HR:   pulse_nxt[2] = 1'b1;
                AL_MIN:  pulse_nxt[3] = 1'b1;
                default: pulse_nxt    = '0;
            endcase
        end
        alarm_nxt = (state_nxt == AL_HR) || (state_nxt == AL_MIN);
        run_nxt   = !((state_nxt == SET_HR) || (state_nxt == SET_MIN));
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Directed and randomized stimulus for clock_set_ctrl, checked every cycle
// against a behavioural model. The model tracks the panel in terms of a mode
// index, sample ticks since the last INC press and ticks since last activity.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int unsigned SDIV = 4;
    localparam int unsigned HOLD = 3;
    localparam int unsigned REP  = 2;
    localparam int unsigned IDLE = 10;

    logic       cclk     = 1'b0;
    logic       clr      = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic       sample_en;
    logic [2:0] mode;
    logic       alarm_d;
    logic       run_en;
    logic       inc_hr;
    logic       inc_min;
    logic       al_inc_hr;
    logic       al_inc_min;
    logic [3:0] pulses;

    clock_set_ctrl #(
        .SAMPLE_DIV   (SDIV),
        .HOLD_TICKS   (HOLD),
        .REPEAT_TICKS (REP),
        .IDLE_TICKS   (IDLE)
    ) dut (
        .cclk       (cclk),
        .clr        (clr),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sample_en  (sample_en),
        .mode       (mode),
        .alarm_d    (alarm_d),
        .run_en     (run_en),
        .inc_hr     (inc_hr),
        .inc_min    (inc_min),
        .al_inc_hr  (al_inc_hr),
        .al_inc_min (al_inc_min)
    );

    assign pulses = {al_inc_min, al_inc_hr, inc_min, inc_hr};

    always #5 cclk = ~cclk;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    int         m_mode;
    int         m_cyc;
    int         m_ticks;
    int         m_idle;
    bit         m_sample;
    bit         m_held;
    bit         prev_bm;
    bit         prev_bi;
    logic [3:0] exp_pulse;
    int         pulse_seen [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_cyc     = 0;
        m_ticks   = 0;
        m_idle    = 0;
        m_sample  = 1'b0;
        m_held    = 1'b0;
        prev_bm   = 1'b0;
        prev_bi   = 1'b0;
        exp_pulse = '0;
    endtask

    // One rising edge of the panel, given the button levels at that edge.
    task automatic model_update(input bit bm, input bit bi);
        bit rise_m;
        bit rise_i;
        bit fire;
        int new_mode;
        rise_m   = bm && !prev_bm;
        rise_i   = bi && !prev_bi;
        fire     = 1'b0;
        new_mode = m_mode;
        if (rise_m) begin
            new_mode = (m_mode + 1) % 5;
            m_held   = 1'b0;
            m_ticks  = 0;
            m_idle   = 0;
        end else if (m_mode == 0) begin
            m_held = 1'b0;
            m_idle = 0;
        end else begin
            if (rise_i) begin
                fire    = 1'b1;
                m_held  = 1'b1;
                m_ticks = 0;
            end else if (!bi) begin
                m_held = 1'b0;
            end else if (m_held && m_sample) begin
                m_ticks++;
                if (m_ticks == HOLD || (m_ticks > HOLD && (m_ticks - HOLD) % REP == 0))
                    fire = 1'b1;
            end
            if (rise_i || fire) begin
                m_idle = 0;
            end else if (m_sample) begin
                m_idle++;
                if (m_idle == IDLE) begin
                    new_mode = 0;
                    m_held   = 1'b0;
                    m_idle   = 0;
                end
            end
        end
        exp_pulse = fire ? 4'(1 << (m_mode - 1)) : 4'b0000;
        m_mode    = new_mode;
        m_cyc++;
        m_sample  = (m_cyc % SDIV) == 0;
        prev_bm   = bm;
        prev_bi   = bi;
    endtask

    task automatic check_outputs();
        check("mode", 32'(mode), 32'(m_mode));
        check("alarm_d", 32'(alarm_d), 32'(m_mode == 3 || m_mode == 4));
        check("run_en", 32'(run_en), 32'(!(m_mode == 1 || m_mode == 2)));
        check("sample_en", 32'(sample_en), 32'(m_sample));
        check("pulses", 32'(pulses), 32'(exp_pulse));
        check("one_pulse_max", 32'($countones(pulses) <= 1), 32'd1);
        for (int i = 0; i < 4; i++)
            if (pulses[i] === 1'b1) pulse_seen[i]++;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) pulse_seen[i] = 0;
    endtask

    // Drive button levels, take one edge, then compare just after it.
    task automatic step(input bit bm, input bit bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge cclk);
        model_update(bm, bi);
        #1;
        check_outputs();
    endtask

    // Keep clr low for n edges with buttons toggling, then release mid-cycle.
    task automatic reset_hold(input int n);
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge cclk);
            #1;
            check_outputs();
            btn_mode = 1'($urandom_range(0, 1));
            btn_inc  = 1'($urandom_range(0, 1));
        end
        @(negedge cclk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        clr      = 1'b1;
    endtask

    task automatic press_mode(input bit bi);
        repeat (3) step(1'b1, bi);
        repeat (3) step(1'b0, bi);
    endtask

    initial begin : main
        int seq [5];
        int first_se;
        int se_count;
        bit rbm;
        bit rbi;
        seq = '{1, 2, 3, 4, 0};
        clear_seen();

        // Reset with buttons active
        reset_hold(6);

        // Prescaler phase after release
        first_se = -1;
        se_count = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0);
            if (sample_en === 1'b1) begin
                se_count++;
                if (first_se < 0) first_se = i;
            end
        end
        check("first_sample_cycle", 32'(first_se), 32'd4);
        check("sample_count_12", 32'(se_count), 32'd3);

        // Mode cycling
        for (int k = 0; k < 5; k++) begin
            press_mode(1'b0);
            check("mode_seq", 32'(mode), 32'(seq[k]));
        end

        // Short INC in SET_MIN
        press_mode(1'b0);
        press_mode(1'b0);
        check("in_set_min", 32'(mode), 32'd2);
        clear_seen();
        repeat (5) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        check("short_inc_min", 32'(pulse_seen[1]), 32'd1);
        check("short_other", 32'(pulse_seen[0] + pulse_seen[2] + pulse_seen[3]), 32'd0);

        // Hold / repeat in AL_HR
        press_mode(1'b0);
        check("in_al_hr", 32'(mode), 32'd3);
        clear_seen();
        repeat (40) step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);
        check("hold_al_inc_hr", 32'(pulse_seen[2]), 32'd5);
        check("hold_other", 32'(pulse_seen[0] + pulse_seen[1] + pulse_seen[3]), 32'd0);

        // Simultaneous MODE and INC edge in SET_HR
        press_mode(1'b0);
        press_mode(1'b0);
        press_mode(1'b0);
        check("in_set_hr", 32'(mode), 32'd1);
        clear_seen();
        repeat (3) step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("simul_mode", 32'(mode), 32'd2);
        check("simul_no_pulse", 32'(pulse_seen[0] + pulse_seen[1] + pulse_seen[2] + pulse_seen[3]), 32'd0);

        // INC presses in RUN
        press_mode(1'b0);
        press_mode(1'b0);
        press_mode(1'b0);
        check("in_run", 32'(mode), 32'd0);
        clear_seen();
        for (int k = 0; k < 3; k++) begin
            repeat (3) step(1'b0, 1'b1);
            repeat (3) step(1'b0, 1'b0);
        end
        repeat (16) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("run_no_pulse", 32'(pulse_seen[0] + pulse_seen[1] + pulse_seen[2] + pulse_seen[3]), 32'd0);

        // Idle timeout from SET_HR
        press_mode(1'b0);
        check("timeout_entry", 32'(mode), 32'd1);
        repeat (44) step(1'b0, 1'b0);
        check("timeout_mode", 32'(mode), 32'd0);

        // Reset during auto-repeat
        press_mode(1'b0);
        clear_seen();
        repeat (24) step(1'b0, 1'b1);
        check("pre_reset_pulses", 32'(pulse_seen[0]), 32'd3);
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check_outputs();
        reset_hold(3);
        clear_seen();
        repeat (8) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        check("post_reset_no_pulse", 32'(pulse_seen[0] + pulse_seen[1] + pulse_seen[2] + pulse_seen[3]), 32'd0);
        check("post_reset_mode", 32'(mode), 32'd0);

        // Randomized button activity
        rbm = 1'b0;
        rbi = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) rbm = ~rbm;
            if ($urandom_range(0, 14) == 0) rbi = ~rbi;
            step(rbm, rbi);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
